// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NUM_REQ requesters.
// Optional REGFILE_ARB_PRIO0_EN: requester 0 wins outright, the rest share round-robin.
module regfile_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           wr_stall,
  output logic                           wr_en,
  output logic [ADDR_BITS-1:0]           wr_addr,
  output logic [DATA_BITS-1:0]           wr_data,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id
);

  localparam int unsigned ID_BITS = $clog2(NUM_REQ);

  logic [ID_BITS-1:0]   rr_ptr;
  logic [ID_BITS-1:0]   grant_idx;
  logic [ID_BITS-1:0]   ptr_next;
  logic [ID_BITS:0]     cand;
  logic [NUM_REQ-1:0]   grant;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0] sel_data;
  logic                 found;
  logic                 accept;
  logic                 adv_ptr;

  // Output register is free when empty or when the held write drains this cycle.
  assign accept = reset_n && (!wr_en || !wr_stall);

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    if (accept) begin
`ifdef REGFILE_ARB_PRIO0_EN
      found = req_valid[0];
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = (ID_BITS+1)'(rr_ptr) + (ID_BITS+1)'(k);
        if (cand >= (ID_BITS+1)'(NUM_REQ)) cand = cand - (ID_BITS+1)'(NUM_REQ);
        if (!found && req_valid[cand[ID_BITS-1:0]]) begin
          found     = 1'b1;
          grant_idx = cand[ID_BITS-1:0];
        end
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  assign req_ready = grant;

  // Payload mux driven by the one-hot grant.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_BITS +: ADDR_BITS];
        sel_data = req_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  assign ptr_next = (grant_idx == ID_BITS'(NUM_REQ-1)) ? '0 : grant_idx + ID_BITS'(1);

`ifdef REGFILE_ARB_PRIO0_EN
  assign adv_ptr = (grant_idx != '0);
`else
  assign adv_ptr = 1'b1;
`endif

  // Output register and round-robin pointer; a stall freezes everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else if (accept) begin
      if (found) begin
        wr_en    <= 1'b1;
        wr_addr  <= sel_addr;
        wr_data  <= sel_data;
        grant_id <= grant_idx;
        if (adv_ptr) rr_ptr <= ptr_next;
      end else begin
        wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port between NUM_REQ requesters, for example the ALU writeback, load return and immediate load.
- Arbitration is round-robin.
- The registered output drives the write-enable, the 1-to-16 demux select (wr_addr) and the data bus of the register file.
- One write is committed per cycle. A downstream stall holds the pending write.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_BITS, 4, register address width (demux select width).
- DATA_BITS, 8, write data width.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ*ADDR_BITS  flattened addresses; requester i uses bits [i*ADDR_BITS +: ADDR_BITS].
- req_data  input  NUM_REQ*DATA_BITS  flattened data; requester i uses bits [i*DATA_BITS +: DATA_BITS].
- req_ready  output  NUM_REQ  one-hot grant, combinational, this cycle.
- wr_stall  input  1  register file cannot accept the write this cycle.
- wr_en  output  1  registered write strobe.
- wr_addr  output  ADDR_BITS  registered register address (demux sel).
- wr_data  output  DATA_BITS  registered write data.
- grant_id  output  $clog2(NUM_REQ)  index of the requester owning the current wr_en.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, grant_id=0.
  - rr_ptr=0.
  - req_ready=0 while reset_n=0.
- accept = !wr_en || !wr_stall. The output register can take a new write when this is true.
- Arbitration, combinational:
  - If accept=1, req_ready is one-hot on the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - If accept=0 or no requester is valid, req_ready=0.
- A transfer occurs when req_valid[i] && req_ready[i]. Requesters must hold valid, addr and data stable until ready.
- On the clock edge:
  - Transfer to i: wr_en<=1, wr_addr<=req_addr[i], wr_data<=req_data[i], grant_id<=i, rr_ptr<=(i+1) mod NUM_REQ.
  - accept=1 with no transfer: wr_en<=0. wr_addr, wr_data and grant_id hold. rr_ptr holds.
  - accept=0 (wr_en=1 and wr_stall=1): all outputs and rr_ptr hold.
- Latency: the write appears on wr_en one cycle after the transfer cycle.
- Throughput: with wr_stall=0, back-to-back grants give one write per cycle.
- Stall release: if wr_stall deasserts while wr_en=1, the held write commits that cycle. A new grant is issued in the same cycle, so there is no bubble.
- Simultaneous requests: exactly one grant per cycle.
  - A requester that is continuously valid is granted within NUM_REQ accepting cycles (starvation-free).
- Out-of-range pointer: rr_ptr wraps from NUM_REQ-1 to 0. When NUM_REQ is not a power of 2, rr_ptr never takes an out-of-range value.
- Same-address writes: consecutive writes to the same address are not merged. Each is committed in grant order.
- Reset mid-operation: the pending write is dropped (wr_en=0 immediately) and rr_ptr returns to 0. No partial write is emitted.

Optional Feature:
- Macro: REGFILE_ARB_PRIO0_EN.
- Defined:
  - Requester 0 has fixed absolute priority. If req_valid[0]=1 and accept=1, requester 0 is granted regardless of rr_ptr.
  - Requesters 1..NUM_REQ-1 arbitrate round-robin among themselves using rr_ptr.
  - rr_ptr does not advance on a grant to requester 0.
- Undefined: pure round-robin over all requesters, as described above.

Test Plan:
- Reset checks: assert reset_n=0 mid-write while wr_en=1 -> wr_en=0 asynchronously, before the next edge. After release, a grant to requester 3 with rr_ptr=0 and only req_valid=4'b1000 -> grant_id=3, and the next search starts at 0.
- Single requester: req_valid=4'b0010, addr=5, data=8'hA5, wr_stall=0 -> req_ready=4'b0010 the same cycle. Next cycle wr_en=1, wr_addr=5, wr_data=8'hA5, grant_id=1.
- Round-robin fairness: req_valid=4'b1111 held for 8 cycles, no stall -> grant order 0,1,2,3,0,1,2,3 and wr_en=1 every cycle. With the macro defined -> 0 on every cycle.
- Stall hold: wr_en=1 (addr=2, data=8'h11), wr_stall=1 for 3 cycles with req_valid=4'b0100 -> req_ready=0 and outputs unchanged for those 3 cycles. The cycle wr_stall drops -> req_ready=4'b0100, and the next cycle shows the new write.
- Idle gap: a single transfer followed by req_valid=0 -> wr_en is high for exactly 1 cycle, then 0. wr_addr and wr_data retain their last values.
- Starvation: requester 2 valid continuously, others toggling randomly, no stall -> requester 2 is granted within 4 cycles every time.
